// File: rtl/seg_scan_driver.sv
// Purpose : latch six character codes once per frame, decode to 7-seg, scan digits with optional blink.
// Latency : seg_out/dig_sel are registered, 1 cycle after the prescaler/index state they reflect.
// Backpr. : none; inputs are sampled only at frame boundaries (or continuously while disabled).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enable             0 = dark, counters held cleared, shadow codes track inputs
//   Seg1..Seg6         6-bit character codes, Seg1 = leftmost = digit 0
//   twinkle            blink request; blink_mask[i] selects digit i for blinking
//   seg_out            {dp,g,f,e,d,c,b,a} at pin polarity
//   dig_sel            one-hot digit enable at pin polarity, bit i = digit i
//   frame_done         1-cycle pulse when the digit index wraps 5 -> 0
module seg_scan_driver #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYC    = 2000,
    parameter int BLINK_FRAMES = 64,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit DIG_ACT_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [5:0] Seg1,
    input  logic [5:0] Seg2,
    input  logic [5:0] Seg3,
    input  logic [5:0] Seg4,
    input  logic [5:0] Seg5,
    input  logic [5:0] Seg6,
    input  logic       twinkle,
    input  logic [5:0] blink_mask,
    output logic [7:0] seg_out,
    output logic [5:0] dig_sel,
    output logic       frame_done
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);
    localparam logic [7:0]    SEG_POL   = {8{SEG_ACT_LOW}};
    localparam logic [5:0]    DIG_POL   = {6{DIG_ACT_LOW}};
    localparam logic [5:0]    CODE_BLANK = 6'd16;

    // Character code to active-high segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [5:0] code);
        logic [6:0] s;
        case (code)
            6'd0:  s = 7'h3F;
            6'd1:  s = 7'h06;
            6'd2:  s = 7'h5B;
            6'd3:  s = 7'h4F;
            6'd4:  s = 7'h66;
            6'd5:  s = 7'h6D;
            6'd6:  s = 7'h7D;
            6'd7:  s = 7'h07;
            6'd8:  s = 7'h7F;
            6'd9:  s = 7'h6F;
            6'd10: s = 7'h77;
            6'd11: s = 7'h7C;
            6'd12: s = 7'h39;
            6'd13: s = 7'h5E;
            6'd14: s = 7'h79;
            6'd15: s = 7'h71;
            6'd17: s = 7'h40;  // '-'
            6'd18: s = 7'h73;  // P
            6'd19: s = 7'h38;  // L
            6'd20: s = 7'h3E;  // U
            6'd21: s = 7'h6D;  // S
            6'd22: s = 7'h50;  // r
            6'd23: s = 7'h54;  // n
            6'd24: s = 7'h5C;  // o
            6'd25: s = 7'h78;  // t
            6'd26: s = 7'h76;  // H
            6'd27: s = 7'h6E;  // Y
            default: s = 7'h00;  // 16 and 28..63 are blank
        endcase
        return s;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          phase_q, phase_d;
    logic [5:0]    shadow_q [6];
    logic [5:0]    shadow_d [6];
    logic          frame_done_q, frame_done_d;
    logic [7:0]    seg_out_q, seg_out_d;
    logic [5:0]    dig_sel_q, dig_sel_d;

    logic          slot_end;
    logic          frame_end;
    logic          lit;
    logic [7:0]    seg_int;
    logic [5:0]    dig_int;

    always_comb begin
        presc_d      = presc_q;
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        phase_d      = phase_q;
        shadow_d     = shadow_q;
        frame_done_d = 1'b0;
        seg_int      = 8'h00;
        dig_int      = 6'h00;

        slot_end  = (presc_q == PRESC_MAX);
        frame_end = slot_end && (idx_q == 3'd5);

        if (!enable) begin
            // Held cleared; shadow follows inputs so re-enable shows fresh codes.
            presc_d     = '0;
            idx_d       = 3'd0;
            frame_cnt_d = '0;
            phase_d     = 1'b0;
            shadow_d[0] = Seg1;
            shadow_d[1] = Seg2;
            shadow_d[2] = Seg3;
            shadow_d[3] = Seg4;
            shadow_d[4] = Seg5;
            shadow_d[5] = Seg6;
        end else begin
            if (slot_end) begin
                presc_d = '0;
                idx_d   = frame_end ? 3'd0 : idx_q + 3'd1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
            // Tear-free latch: codes only change between frames.
            if (frame_end) begin
                shadow_d[0]  = Seg1;
                shadow_d[1]  = Seg2;
                shadow_d[2]  = Seg3;
                shadow_d[3]  = Seg4;
                shadow_d[4]  = Seg5;
                shadow_d[5]  = Seg6;
                frame_done_d = 1'b1;
                if (frame_cnt_q == FRAME_MAX) begin
                    frame_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
        end

        // Leading blank interval hides ghosting while digit drivers switch.
        lit = enable && (presc_q >= BLANK_END) &&
              !(twinkle && blink_mask[idx_q] && phase_q);
        if (lit) begin
            dig_int = 6'b000001 << idx_q;
            seg_int = {1'b0, decode(shadow_q[idx_q])};
        end

        seg_out_d = seg_int ^ SEG_POL;
        dig_sel_d = dig_int ^ DIG_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= 3'd0;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= CODE_BLANK;
            end
            frame_done_q <= 1'b0;
            seg_out_q    <= SEG_POL;
            dig_sel_q    <= DIG_POL;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
            shadow_q     <= shadow_d;
            frame_done_q <= frame_done_d;
            seg_out_q    <= seg_out_d;
            dig_sel_q    <= dig_sel_d;
        end
    end

    assign seg_out    = seg_out_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [5:0] Seg1, Seg2, Seg3, Seg4, Seg5, Seg6;
    logic       twinkle;
    logic [5:0] blink_mask;
    logic [7:0] seg_out;
    logic [5:0] dig_sel;
    logic       frame_done;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .SCAN_DIV    (4),
        .BLANK_CYC   (1),
        .BLINK_FRAMES(2),
        .SEG_ACT_LOW (1'b0),
        .DIG_ACT_LOW (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .Seg1      (Seg1),
        .Seg2      (Seg2),
        .Seg3      (Seg3),
        .Seg4      (Seg4),
        .Seg5      (Seg5),
        .Seg6      (Seg6),
        .twinkle   (twinkle),
        .blink_mask(blink_mask),
        .seg_out   (seg_out),
        .dig_sel   (dig_sel),
        .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, ".seg"}, seg_out, 8'h00);
        chk({tag, ".dig"}, {2'b00, dig_sel}, 8'h00);
        chk({tag, ".fd"},  {7'b0, frame_done}, 8'h00);
    endtask

    // Walk ncyc edges of a frame that starts with prescaler=0, digit 0.
    // After edge k the outputs reflect slot (k-1)/4, prescaler (k-1)%4;
    // prescaler 0 is the blank cycle. segs packs digit i in [8*i +: 8].
    // At edge chg_k (if nonzero) Seg1 is changed to chg_val mid-frame.
    task automatic run_frame(input string tag, input logic [47:0] segs,
                             input logic [5:0] vis, input int ncyc,
                             input int chg_k, input logic [5:0] chg_val);
        logic [7:0] exp_seg;
        logic [5:0] exp_dig;
        int p, d;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            @(negedge clk);
            p = (k - 1) % 4;
            d = (k - 1) / 4;
            exp_seg = 8'h00;
            exp_dig = 6'h00;
            if (p != 0 && vis[d]) begin
                exp_dig = 6'b000001 << d;
                exp_seg = segs[8*d +: 8];
            end
            chk($sformatf("%s.k%0d.seg", tag, k), seg_out, exp_seg);
            chk($sformatf("%s.k%0d.dig", tag, k), {2'b00, dig_sel}, {2'b00, exp_dig});
            chk($sformatf("%s.k%0d.fd", tag, k), {7'b0, frame_done},
                (k == 24) ? 8'h01 : 8'h00);
            if (k == chg_k) Seg1 = chg_val;
        end
    endtask

    localparam logic [47:0] S_123456 = {8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06};
    localparam logic [47:0] S_023456 = {8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h3F};
    localparam logic [47:0] S_823456 = {8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h7F};
    localparam logic [47:0] S_LETTER = {8'h00, 8'h50, 8'h6D, 8'h3E, 8'h38, 8'h73};
    localparam logic [47:0] S_LET_7  = {8'h07, 8'h50, 8'h6D, 8'h3E, 8'h38, 8'h73};
    localparam logic [47:0] S_BLANK  = 48'h0;

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        Seg1 = 6'd1; Seg2 = 6'd2; Seg3 = 6'd3;
        Seg4 = 6'd4; Seg5 = 6'd5; Seg6 = 6'd6;
        twinkle = 1'b0;
        blink_mask = 6'h00;

        // Reset state
        repeat (2) @(negedge clk);
        chk_dark("reset");

        // Disabled: dark, shadow tracks inputs
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_dark("disabled");

        // Codes 1..6, two full frames
        enable = 1'b1;
        run_frame("f0", S_123456, 6'h3F, 24, 0, 6'd0);
        run_frame("f1", S_123456, 6'h3F, 24, 0, 6'd0);

        // Tear-free latching: Seg1 -> 0, then -> 8 mid-frame
        Seg1 = 6'd0;
        run_frame("f2", S_123456, 6'h3F, 24, 0, 6'd0);
        run_frame("f3", S_023456, 6'h3F, 24, 10, 6'd8);
        run_frame("f4", S_823456, 6'h3F, 24, 0, 6'd0);

        // Blink digit 0: phase 0 in f4/f5, 1 in f6/f7, 0 in f8/f9
        twinkle = 1'b1;
        blink_mask = 6'b000001;
        run_frame("f5", S_823456, 6'h3F, 24, 0, 6'd0);
        run_frame("f6", S_823456, 6'h3E, 24, 0, 6'd0);
        run_frame("f7", S_823456, 6'h3E, 24, 0, 6'd0);
        run_frame("f8", S_823456, 6'h3F, 24, 0, 6'd0);
        run_frame("f9", S_823456, 6'h3F, 24, 0, 6'd0);

        // Phase is 1 in f10, but twinkle=0 keeps digit 0 visible
        twinkle = 1'b0;
        Seg1 = 6'd18; Seg2 = 6'd19; Seg3 = 6'd20;
        Seg4 = 6'd21; Seg5 = 6'd22; Seg6 = 6'd40;
        run_frame("f10", S_823456, 6'h3F, 24, 0, 6'd0);
        run_frame("f11", S_LETTER, 6'h3F, 24, 0, 6'd0);

        // Drop enable after slot 3's second cycle
        run_frame("f12", S_LETTER, 6'h3F, 14, 0, 6'd0);
        enable = 1'b0;
        Seg6 = 6'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk_dark($sformatf("en_low%0d", i));
        end
        enable = 1'b1;
        run_frame("reen", S_LET_7, 6'h3F, 24, 0, 6'd0);

        // Async reset mid-slot 2
        run_frame("prerst", S_LET_7, 6'h3F, 9, 0, 6'd0);
        #2 rst_n = 1'b0;
        #1 chk_dark("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("rst_f0", S_BLANK, 6'h3F, 24, 0, 6'd0);
        run_frame("rst_f1", S_LET_7, 6'h3F, 24, 0, 6'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
